// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg
//
// Shared types for the IFU/LSU memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, REQ, WAIT)
//   arb_owner_t : which master owns the transaction in flight
// ----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for a master request
        REQ  = 2'd1,  // driving the captured request downstream
        WAIT = 2'd2   // request accepted, waiting for the memory response
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_t;

    localparam int unsigned ArbWidthDefault = 32;

endpackage

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory port between the instruction fetch unit (IFU, read-only)
// and the load/store unit (LSU). One transaction is in flight at a time: a
// request is captured in IDLE, presented downstream in REQ until accepted,
// and the single response is routed back to its owner from WAIT.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   ifu_req_valid/ready : IFU request handshake, ifu_addr carries the address
//   lsu_req_valid/ready : LSU request handshake, lsu_addr/we/wdata/wmask
//   ifu_rsp_valid/rdata : IFU one-cycle response pulse and held read data
//   lsu_rsp_valid/rdata : LSU one-cycle response pulse and held read data
//   mem_req_valid/ready : downstream request handshake
//   mem_addr/we/wdata/wmask : downstream request payload (capture registers)
//   mem_rsp_valid/rdata : downstream response
//   busy                : high whenever the FSM is not in IDLE
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH = ArbWidthDefault
) (
    input  logic               clk,
    input  logic               rst,

    // IFU request / response
    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [WIDTH-1:0]   ifu_addr,
    output logic               ifu_rsp_valid,
    output logic [WIDTH-1:0]   ifu_rdata,

    // LSU request / response
    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [WIDTH-1:0]   lsu_addr,
    input  logic               lsu_we,
    input  logic [WIDTH-1:0]   lsu_wdata,
    input  logic [WIDTH/8-1:0] lsu_wmask,
    output logic               lsu_rsp_valid,
    output logic [WIDTH-1:0]   lsu_rdata,

    // Memory request / response
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [WIDTH-1:0]   mem_addr,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [WIDTH/8-1:0] mem_wmask,
    input  logic               mem_rsp_valid,
    input  logic [WIDTH-1:0]   mem_rsp_rdata,

    output logic               busy
);

    localparam int unsigned MaskW = WIDTH / 8;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    arb_state_t       state_q, state_d;
    arb_owner_t       owner_q, owner_d;
    arb_owner_t       last_grant_q, last_grant_d;

    logic [WIDTH-1:0] addr_q, addr_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [MaskW-1:0] wmask_q, wmask_d;

    logic [WIDTH-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;
    logic             ifu_rsp_q, ifu_rsp_d;
    logic             lsu_rsp_q, lsu_rsp_d;

    // ------------------------------------------------------------------------
    // Winner pick. Only meaningful in IDLE; a tie goes to the master that was
    // not granted last, so two continuously-requesting masters alternate.
    // Because ready is only raised for a valid master, grant == handshake.
    // ------------------------------------------------------------------------
    logic grant_ifu;
    logic grant_lsu;

    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state_q == IDLE) begin
            if (ifu_req_valid && lsu_req_valid) begin
                if (last_grant_q == OWN_IFU) begin
                    grant_lsu = 1'b1;
                end else begin
                    grant_ifu = 1'b1;
                end
            end else if (ifu_req_valid) begin
                grant_ifu = 1'b1;
            end else if (lsu_req_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_ifu || grant_lsu) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Responses seen in IDLE or REQ are strays and ignored.
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath next state: request capture, ownership and response routing
    // ------------------------------------------------------------------------
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        ifu_rdata_d  = ifu_rdata_q;
        lsu_rdata_d  = lsu_rdata_q;
        ifu_rsp_d    = 1'b0;
        lsu_rsp_d    = 1'b0;

        if (grant_ifu) begin
            // IFU only ever reads; clear the write payload so the memory
            // side never sees stale LSU write data.
            addr_d       = ifu_addr;
            we_d         = 1'b0;
            wdata_d      = '0;
            wmask_d      = '0;
            owner_d      = OWN_IFU;
            last_grant_d = OWN_IFU;
        end else if (grant_lsu) begin
            addr_d       = lsu_addr;
            we_d         = lsu_we;
            wdata_d      = lsu_wdata;
            wmask_d      = lsu_wmask;
            owner_d      = OWN_LSU;
            last_grant_d = OWN_LSU;
        end

        if (state_q == WAIT && mem_rsp_valid) begin
            if (owner_q == OWN_IFU) begin
                ifu_rdata_d = mem_rsp_rdata;
                ifu_rsp_d   = 1'b1;
            end else begin
                lsu_rdata_d = mem_rsp_rdata;
                lsu_rsp_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
            ifu_rsp_q    <= 1'b0;
            lsu_rsp_q    <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            ifu_rdata_q  <= ifu_rdata_d;
            lsu_rdata_q  <= lsu_rdata_d;
            ifu_rsp_q    <= ifu_rsp_d;
            lsu_rsp_q    <= lsu_rsp_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    assign mem_req_valid = (state_q == REQ);
    assign mem_addr      = addr_q;
    assign mem_we        = we_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign ifu_rsp_valid = ifu_rsp_q;
    assign ifu_rdata     = ifu_rdata_q;
    assign lsu_rsp_valid = lsu_rsp_q;
    assign lsu_rdata     = lsu_rdata_q;

    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed scenarios followed by a randomized run. A negedge monitor keeps a
// transaction-level reference of the arbiter: expected downstream requests
// are queued when a master is granted, expected responses are queued when
// the bench memory answers, and both are popped and compared as the DUT
// presents them.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
    logic [W-1:0]  ifu_addr, ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid;
    logic [W-1:0]  lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]    lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [W-1:0]  mem_addr, mem_wdata, mem_rsp_rdata;
    logic [3:0]    mem_wmask;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rdata     (ifu_rdata),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_we        (lsu_we),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rdata     (lsu_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .busy          (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Bench memory and master knobs
    // ------------------------------------------------------------------------
    bit          auto_ifu      = 0;
    bit          auto_lsu      = 0;
    bit          stray_en      = 0;
    bit          lat_rand      = 0;
    int          lat_fixed     = 0;
    int          ready_pct     = 100;
    bit          rdata_fix_en  = 0;
    logic [31:0] rdata_fix     = '0;
    bit          outstanding   = 0;
    int          lat_cnt       = 0;

    // Handshake flags sampled by the monitor, consumed by the next step().
    bit ifu_hs  = 0;
    bit lsu_hs  = 0;
    bit mem_acc = 0;

    // Advance one cycle and update all bench-driven inputs.
    task automatic step();
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        if (rst) begin
            outstanding = 0;  // memory drops its in-flight access on reset
        end else begin
            if (mem_acc) begin
                outstanding = 1;
                lat_cnt     = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
            end
            if (outstanding) begin
                if (lat_cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = rdata_fix_en ? rdata_fix : $urandom;
                    outstanding   = 0;
                end else begin
                    lat_cnt--;
                end
            end else if (stray_en && $urandom_range(0, 7) == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = $urandom;
            end
        end
        mem_req_ready = ($urandom_range(0, 99) < ready_pct);
        if (auto_ifu && (ifu_hs || !ifu_req_valid)) begin
            ifu_req_valid = ($urandom_range(0, 2) != 0);
            ifu_addr      = $urandom;
        end
        if (auto_lsu && (lsu_hs || !lsu_req_valid)) begin
            lsu_req_valid = ($urandom_range(0, 2) != 0);
            lsu_addr      = $urandom;
            lsu_we        = 1'($urandom_range(0, 1));
            lsu_wdata     = $urandom;
            lsu_wmask     = 4'($urandom);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        bit          owner;  // 0 = IFU, 1 = LSU
    } req_t;

    typedef struct {
        bit          owner;
        logic [31:0] rdata;
    } rsp_t;

    req_t        mem_exp[$];
    rsp_t        rsp_exp[$];
    int          phase       = 0;  // 0 none in flight, 1 awaiting mem accept, 2 awaiting mem rsp
    bit          m_last      = 0;  // last granted master
    bit          pulse_due   = 0;
    logic [31:0] m_ifu_rdata = '0;
    logic [31:0] m_lsu_rdata = '0;

    always @(negedge clk) begin
        int   win;
        req_t n;
        rsp_t r;
        if (rst) begin
            phase = 0; m_last = 0; pulse_due = 0;
            m_ifu_rdata = '0; m_lsu_rdata = '0;
            mem_exp.delete(); rsp_exp.delete();
            ifu_hs = 0; lsu_hs = 0; mem_acc = 0;
        end else begin
            ifu_hs  = ifu_req_valid && ifu_req_ready;
            lsu_hs  = lsu_req_valid && lsu_req_ready;
            mem_acc = mem_req_valid && mem_req_ready;

            // Response side: a pulse is owed exactly one cycle after mem_rsp_valid in WAIT.
            if (pulse_due) begin
                chk("sb_rsp_queue_depth", rsp_exp.size(), 1);
                if (rsp_exp.size() > 0) begin
                    r = rsp_exp.pop_front();
                    if (r.owner) m_lsu_rdata = r.rdata; else m_ifu_rdata = r.rdata;
                    chk("sb_ifu_rsp_valid", ifu_rsp_valid, !r.owner);
                    chk("sb_lsu_rsp_valid", lsu_rsp_valid, r.owner);
                end
            end else begin
                chk("sb_no_ifu_rsp", ifu_rsp_valid, 0);
                chk("sb_no_lsu_rsp", lsu_rsp_valid, 0);
            end
            pulse_due = 0;
            chk("sb_ifu_rdata", ifu_rdata, m_ifu_rdata);
            chk("sb_lsu_rdata", lsu_rdata, m_lsu_rdata);
            chk("sb_busy", busy, phase != 0);

            if (phase == 0) begin
                chk("sb_idle_mem_valid", mem_req_valid, 0);
                if (ifu_req_valid && lsu_req_valid) win = m_last ? 0 : 1;
                else if (ifu_req_valid)             win = 0;
                else if (lsu_req_valid)             win = 1;
                else                                win = -1;
                chk("sb_ifu_ready", ifu_req_ready, win == 0);
                chk("sb_lsu_ready", lsu_req_ready, win == 1);
                if (win >= 0) begin
                    if (win == 0) begin
                        n.addr = ifu_addr; n.we = 0; n.wdata = '0; n.wmask = '0; n.owner = 0;
                    end else begin
                        n.addr = lsu_addr; n.we = lsu_we; n.wdata = lsu_wdata;
                        n.wmask = lsu_wmask; n.owner = 1;
                    end
                    mem_exp.push_back(n);
                    m_last = (win == 1);
                    phase  = 1;
                end
            end else begin
                chk("sb_busy_ifu_ready", ifu_req_ready, 0);
                chk("sb_busy_lsu_ready", lsu_req_ready, 0);
                if (phase == 1) begin
                    chk("sb_req_mem_valid", mem_req_valid, 1);
                    if (mem_exp.size() > 0) begin
                        chk("sb_mem_addr",  mem_addr,  mem_exp[0].addr);
                        chk("sb_mem_we",    mem_we,    mem_exp[0].we);
                        chk("sb_mem_wdata", mem_wdata, mem_exp[0].wdata);
                        chk("sb_mem_wmask", mem_wmask, mem_exp[0].wmask);
                    end
                    if (mem_req_ready) phase = 2;
                end else begin
                    chk("sb_wait_mem_valid", mem_req_valid, 0);
                    if (mem_rsp_valid) begin
                        chk("sb_req_queue_depth", mem_exp.size(), 1);
                        if (mem_exp.size() > 0) begin
                            n = mem_exp.pop_front();
                            r.owner = n.owner;
                            r.rdata = mem_rsp_rdata;
                            rsp_exp.push_back(r);
                        end
                        pulse_due = 1;
                        phase     = 0;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1;
                break;
            end
            step();
        end
        chk("wait_idle_timeout", done, 1);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int  w;
        bit  found;
        rst = 1'b1;
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_we = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;

        // Reset values
        step();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
        chk("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
        chk("rst_ifu_rdata", ifu_rdata, 0);
        chk("rst_lsu_rdata", lsu_rdata, 0);
        chk("rst_ifu_ready", ifu_req_ready, 0);
        chk("rst_lsu_ready", lsu_req_ready, 0);

        // Tie fairness: both valid from reset release
        step();
        rst = 1'b0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1; lsu_addr = 32'h8000_0200;
        for (int k = 0; k < 4; k++) begin
            w = -1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (lsu_req_valid && lsu_req_ready) w = 1;
                else if (ifu_req_valid && ifu_req_ready) w = 0;
                step();
                if (w >= 0) break;
            end
            chk("tie_grant_order", w, (k % 2 == 0) ? 1 : 0);
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        wait_idle();

        // IFU-only read, latency T..T+3
        rdata_fix_en = 1; rdata_fix = 32'h0000_0413;
        step();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        @(negedge clk);
        chk("ifu_rd_ready_T", ifu_req_ready, 1);
        step();
        ifu_req_valid = 0;
        @(negedge clk);
        chk("ifu_rd_mem_valid_T1", mem_req_valid, 1);
        chk("ifu_rd_mem_addr_T1", mem_addr, 32'h8000_0000);
        chk("ifu_rd_mem_we_T1", mem_we, 0);
        step();
        @(negedge clk);
        chk("ifu_rd_busy_T2", busy, 1);
        step();
        @(negedge clk);
        chk("ifu_rd_rsp_T3", ifu_rsp_valid, 1);
        chk("ifu_rd_rdata_T3", ifu_rdata, 32'h0000_0413);
        chk("ifu_rd_lsu_quiet_T3", lsu_rsp_valid, 0);
        chk("ifu_rd_busy_T3", busy, 0);
        step();
        @(negedge clk);
        chk("ifu_rd_pulse_width", ifu_rsp_valid, 0);
        chk("ifu_rd_rdata_hold", ifu_rdata, 32'h0000_0413);

        // LSU write
        step();
        lsu_req_valid = 1; lsu_addr = 32'h8000_1004; lsu_we = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
        @(negedge clk);
        chk("lsu_wr_ready_T", lsu_req_ready, 1);
        step();
        lsu_req_valid = 0;
        @(negedge clk);
        chk("lsu_wr_mem_we", mem_we, 1);
        chk("lsu_wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("lsu_wr_mem_wmask", mem_wmask, 4'b0011);
        found = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            @(negedge clk);
            if (lsu_rsp_valid) begin
                found = 1;
                break;
            end
        end
        chk("lsu_wr_rsp_seen", found, 1);
        chk("lsu_wr_ifu_quiet", ifu_rsp_valid, 0);

        // Backpressure: mem_req_ready low for 5 cycles, late IFU request
        step();
        lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_we = 0;
        @(negedge clk);
        chk("bp_lsu_ready", lsu_req_ready, 1);
        ready_pct = 0;
        step();
        lsu_req_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_mem_valid", mem_req_valid, 1);
            chk("bp_mem_addr", mem_addr, 32'h8000_2000);
            chk("bp_ifu_ready", ifu_req_ready, 0);
            chk("bp_lsu_ready_low", lsu_req_ready, 0);
            if (i == 4) ready_pct = 100;
            step();
            if (i == 0) begin
                ifu_req_valid = 1; ifu_addr = 32'h8000_3000;
            end
        end
        found = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ifu_req_valid && ifu_req_ready) begin
                found = 1;
                chk("bp_late_ifu_in_idle", busy, 0);
            end
            step();
            if (found) begin
                ifu_req_valid = 0;
                break;
            end
        end
        chk("bp_late_ifu_granted", found, 1);
        wait_idle();

        // Stray responses in IDLE and REQ
        step();
        mem_rsp_valid = 1; mem_rsp_rdata = 32'hBAD0_0001;
        @(negedge clk);
        chk("stray_idle_busy", busy, 0);
        step();
        @(negedge clk);
        chk("stray_idle_no_ifu_rsp", ifu_rsp_valid, 0);
        chk("stray_idle_no_lsu_rsp", lsu_rsp_valid, 0);
        chk("stray_idle_still_idle", busy, 0);
        ready_pct = 0;
        step();
        ifu_req_valid = 1; ifu_addr = 32'h8000_4000;
        @(negedge clk);
        chk("stray_req_ifu_ready", ifu_req_ready, 1);
        step();
        ifu_req_valid = 0;
        mem_rsp_valid = 1; mem_rsp_rdata = 32'hBAD0_0002;
        @(negedge clk);
        chk("stray_req_mem_valid", mem_req_valid, 1);
        step();
        @(negedge clk);
        chk("stray_req_stays_req", mem_req_valid, 1);
        chk("stray_req_no_ifu_rsp", ifu_rsp_valid, 0);
        chk("stray_req_no_lsu_rsp", lsu_rsp_valid, 0);
        ready_pct = 100;
        step();
        wait_idle();

        // Reset while in WAIT
        lat_fixed = 3;
        step();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
        @(negedge clk);
        chk("rw_ifu_ready", ifu_req_ready, 1);
        step();
        ifu_req_valid = 0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rw_busy", busy, 0);
        chk("rw_mem_valid", mem_req_valid, 0);
        chk("rw_mem_addr", mem_addr, 0);
        chk("rw_mem_we", mem_we, 0);
        chk("rw_mem_wdata", mem_wdata, 0);
        chk("rw_mem_wmask", mem_wmask, 0);
        chk("rw_ifu_rdata", ifu_rdata, 0);
        chk("rw_lsu_rdata", lsu_rdata, 0);
        for (int i = 0; i < 4; i++) begin
            chk("rw_no_ifu_rsp", ifu_rsp_valid, 0);
            chk("rw_no_lsu_rsp", lsu_rsp_valid, 0);
            step();
            @(negedge clk);
        end
        lat_fixed = 0; rdata_fix = 32'h1234_5678;
        step();
        ifu_req_valid = 1; ifu_addr = 32'h8000_0080;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ifu_rsp_valid) begin
                found = 1;
                break;
            end
            step();
            ifu_req_valid = 0;
        end
        chk("rw_after_rsp_seen", found, 1);
        chk("rw_after_rdata", ifu_rdata, 32'h1234_5678);

        // Randomized traffic with stray responses and occasional resets
        rdata_fix_en = 0; stray_en = 1; lat_rand = 1; ready_pct = 70;
        auto_ifu = 1; auto_lsu = 1;
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
        end
        step();
        rst = 1'b0;
        auto_ifu = 0; auto_lsu = 0; stray_en = 0; ready_pct = 100;
        ifu_req_valid = 0; lsu_req_valid = 0;
        step();
        wait_idle();
        step();
        @(negedge clk);
        chk("drain_req_queue", mem_exp.size(), 0);
        chk("drain_rsp_queue", rsp_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL global_timeout: simulation did not complete by t=%0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave memory arbiter that shares a single memory port between the instruction fetch unit and the load/store unit. It accepts one request at a time and holds it in capture registers while it drives the memory request channel. It routes the single response back to the owning master. It sits between IFU/LSU and the memory model, replacing their separate memory accesses.

## Interface
- WIDTH, 32, address and data width; the write mask is WIDTH/8 bits
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- ifu_req_valid / lsu_req_valid  in  1  master request valid
- ifu_req_ready / lsu_req_ready  out  1  master request accepted this cycle
- ifu_addr / lsu_addr  in  WIDTH  request address
- lsu_we  in  1  write enable; IFU requests are always reads
- lsu_wdata  in  WIDTH  write data
- lsu_wmask  in  WIDTH/8  byte write mask
- ifu_rsp_valid / lsu_rsp_valid  out  1  one-cycle response pulse; a master cannot backpressure it
- ifu_rdata / lsu_rdata  out  WIDTH  response data; valid only while the matching rsp_valid is high
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream request accepted
- mem_addr  out  WIDTH  downstream address
- mem_we  out  1  downstream write enable
- mem_wdata  out  WIDTH  downstream write data
- mem_wmask  out  WIDTH/8  downstream byte mask
- mem_rsp_valid  in  1  downstream response valid; arrives at least 1 cycle after mem_req_ready
- mem_rsp_rdata  in  WIDTH  downstream read data; a don't-care for writes, which are still acknowledged
- busy  out  1  high in any state other than IDLE

## Operation
- The FSM has three states: IDLE, REQ and WAIT.
- IDLE
  - Winner selection:
    - Only one master valid: that master wins.
    - Both masters valid: the master not recorded in `last_grant` wins.
  - The winner's req_ready is driven high combinationally; the loser's stays low.
  - On the winner's handshake:
    - Capture addr, we, wdata and wmask. For IFU, capture we=0, wdata=0, wmask=0.
    - Set `owner` to the winner and set `last_grant` to the winner.
    - Go to REQ.
- REQ
  - mem_req_valid=1.
  - mem_addr, mem_we, mem_wdata and mem_wmask come from the capture registers and are stable until accepted.
  - When mem_req_ready=1, go to WAIT.
- WAIT
  - mem_req_valid=0.
  - When mem_rsp_valid=1:
    - Register mem_rsp_rdata into the owner's rdata.
    - Pulse the owner's rsp_valid in the next cycle.
    - Go to IDLE.
- mem_rsp_valid is ignored in IDLE and REQ; no state changes.
- Both req_ready outputs are 0 in REQ and WAIT.
- The non-owner's rsp_valid is never asserted.

## Timing
- Reset values:
  - State IDLE, `last_grant`=IFU, so LSU wins the first tie.
  - All outputs 0, including mem_*, *_rsp_valid, *_rdata and busy.
- Latency, with memory ready immediately and responding 1 cycle after acceptance:
  - Master handshake at cycle T.
  - mem_req_valid high at T+1.
  - mem_rsp_valid at T+2.
  - rsp_valid pulse at T+3.
  - A new master request can be accepted at T+3.
- Throughput is at most one transaction per 3 cycles.
- No outstanding-transaction overlap is allowed.
- busy: high from T+1 through the cycle of mem_rsp_valid; low in the cycle of the rsp_valid pulse.
- rsp_valid is exactly 1 cycle wide. rdata holds its value until the next response to the same master.
- Reset mid-operation, in REQ or WAIT:
  - Return to IDLE and drop `owner`.
  - Emit no rsp pulse.
  - The memory model shares rst and discards its own in-flight access.
- Master request valid rising while in REQ/WAIT: the request waits; its ready stays low.
- Master contract: a master must hold addr/data stable while valid && !ready.

## Structure
- Shared package `mem_pkg`:
  - `arb_state_t` enum: IDLE, REQ, WAIT.
  - `arb_owner_t` enum: OWN_IFU, OWN_LSU.
- Single module with no sub-module. The winner-pick is a small combinational block inside the module.
- Capture registers, `owner` and `last_grant` are plain flops in one always_ff block.

## Test plan
- IFU-only read: IFU addr 0x8000_0000 valid, memory ready immediately and rdata 0x0000_0413 one cycle later. Required: ifu_req_ready at T, mem_addr 0x8000_0000 with mem_we=0 at T+1, ifu_rsp_valid with ifu_rdata 0x0000_0413 at T+3, lsu_rsp_valid stays 0.
- LSU write: addr 0x8000_1004, wdata 0xDEAD_BEEF, wmask 4'b0011. Required: mem_we=1, mem_wdata 0xDEAD_BEEF and mem_wmask 4'b0011 at T+1, lsu_rsp_valid pulse after mem_rsp_valid.
- Tie fairness: both masters valid continuously from reset. Required grant order LSU, IFU, LSU, IFU across four transactions.
- Backpressure: mem_req_ready held low for 5 cycles in REQ. Required: mem_req_valid and mem_addr stable all 5 cycles, both req_ready outputs 0, and a late IFU request not accepted until IDLE.
- Stray response: mem_rsp_valid pulsed in IDLE and again in REQ. Required: no rsp_valid pulse and no state change.
- Reset in WAIT: assert rst for 1 cycle before mem_rsp_valid. Required: next cycle in IDLE with all outputs 0, no rsp pulse; the following IFU request completes normally.
